power1_sweep_ctrl: RTL and testbench
====================================

Name: power1_sweep_ctrl

Overview:
- Sequencer that sweeps all 2^N_BITS input vectors through the combinational power1 block.
- Drives power1's `a` bus from a register and waits a programmable settle time per vector.
- Samples power1's `y` per vector and assembles the full truth table into a register.
- Start/busy/done handshake towards the host; replaces the manual stimulus sweep at block level.

Parameters:
- N_BITS, 3, number of low `a` bits swept (1..4); table width TW = 2^N_BITS.
- SETTLE, 1, extra wait cycles after `a` changes before `y` is sampled (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  sweep request, sampled in IDLE only.
- abort  in  1  cancels a running sweep.
- a  out  4  registered drive to power1 `a`; bits above N_BITS are held 0.
- y  in  1  power1 result.
- busy  out  1  high while a sweep runs.
- done  out  1  one-cycle pulse when a sweep completes.
- table_q  out  TW  captured truth table; bit i = y for vector index i.
- table_vld  out  1  table_q holds a complete sweep.

Behaviour:
- Reset (async, rst_n=0): state IDLE, a=0, busy=0, done=0, table_q=0, table_vld=0, idx=0, settle count=0.
- States: IDLE, RUN, DONE.
- IDLE with start=1 at edge E0:
  - go to RUN; a<=0 (vector 0); idx<=0; busy<=1; table_vld<=0.
  - table_q is not cleared.
- RUN, settle counter:
  - Counts 0..SETTLE.
  - At the edge where count==SETTLE: table_q[idx]<=y, count<=0.
  - If idx<TW-1 at that edge: idx<=idx+1 and a<=idx+1 on the same edge.
- Timing: vector i is sampled at edge E0+(i+1)*(SETTLE+1). Each vector occupies SETTLE+1 cycles. The first sample falls SETTLE+1 cycles after E0.
- Final sample (idx==TW-1):
  - go to DONE; busy<=0; done<=1; table_vld<=1; a<=0.
  - Total sweep: TW*(SETTLE+1) cycles after E0.
- DONE: lasts one cycle, then IDLE; done<=0. table_q and table_vld hold until the next accepted start.
- start while busy: ignored, no queuing.
- start in DONE: ignored; it is accepted only once back in IDLE.
- abort=1 in RUN:
  - next edge goes to IDLE; a<=0; busy<=0; done stays 0; table_vld stays 0.
  - Partial table_q bits remain, undefined for use.
- abort in IDLE/DONE: no effect.
- abort has priority over a sample on the same edge.
- start and abort together in IDLE: start wins, since abort is a no-op in IDLE.
- Index arithmetic: idx is N_BITS wide; a = {zero pad, idx}. No wrap occurs because the final-sample rule exits first.
- Reset mid-sweep: immediate return to reset values; table contents are lost.

Optional Feature:
- Macro: POWER1_SWEEP_CHECK_EN.
- Defined:
  - extra ports exp_table (in, TW) and match (out, 1), plus mismatch_idx (out, N_BITS).
  - In DONE, match<=(table_q==exp_table), using the final sampled bit.
  - mismatch_idx = lowest i where bits differ, 0 if equal.
  - Both are reset to 0 and held until the next start.
- Undefined: the ports do not exist; no compare logic is built.

Decomposition:
- Package power1_sweep_pkg:
  - state enum (IDLE/RUN/DONE);
  - A_W=4;
  - function tw(n)=1<<n.
- One natural sub-module, power1_settle_cnt: a loadable down-counter with a terminal-count flag, used for the settle wait.
- Everything else stays in the top level.

Test Plan:
- Bench model y=^a[2:0], N_BITS=3, SETTLE=1, start pulse → `a` steps 0..7, two cycles each. done pulses at E0+16; table_q=8'h96; table_vld=1; busy high exactly 16 cycles.
- SETTLE=0, model y=&a[2:0] → done at E0+8; table_q=8'h80.
- abort asserted at E0+5 → busy=0 and a=0 next cycle, no done pulse, table_vld=0. A following start completes normally with table_q=8'h96.
- start held high throughout the sweep and in DONE → only one sweep runs; a second sweep begins only after the return to IDLE.
- rst_n low mid-sweep at E0+7 → all outputs go to 0 immediately, without waiting for a clock edge.
- With POWER1_SWEEP_CHECK_EN, exp_table=8'h96 → match=1. With exp_table=8'h97 → match=0, mismatch_idx=0.

Source files
------------

// File: rtl/power1_sweep_pkg.sv
// Shared types and helpers for the power1 truth-table sweep sequencer.
package power1_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int A_W   = 4;  // width of power1's `a` bus
  localparam int CNT_W = 4;  // settle counter width, covers SETTLE 0..15

  function automatic int tw(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/power1_settle_cnt.sv
// Loadable down-counter; tc flags that the settle wait for the current vector is over.
module power1_settle_cnt
  import power1_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state is always updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/power1_sweep_ctrl.sv
// Sweeps every N_BITS-wide vector through power1 and captures y into a truth table.
// Optional golden-table compare is built when POWER1_SWEEP_CHECK_EN is defined.
module power1_sweep_ctrl
  import power1_sweep_pkg::*;
#(
  parameter int N_BITS = 3,
  parameter int SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  output logic [A_W-1:0]          a,
  input  logic                    y,
`ifdef POWER1_SWEEP_CHECK_EN
  input  logic [tw(N_BITS)-1:0]   exp_table,
  output logic                    match,
  output logic [N_BITS-1:0]       mismatch_idx,
`endif
  output logic                    busy,
  output logic                    done,
  output logic [tw(N_BITS)-1:0]   table_q,
  output logic                    table_vld
);

  localparam int                TW   = tw(N_BITS);
  localparam logic [N_BITS-1:0] LAST = N_BITS'(TW - 1);

  state_t            state, state_d;
  logic [N_BITS-1:0] idx, idx_inc;
  logic              tc, accept, kill, sample, last, cnt_load;
  logic [CNT_W-1:0]  cnt_val;

  assign accept  = (state == IDLE) && start;
  assign kill    = (state == RUN) && abort;
  assign sample  = (state == RUN) && !abort && tc;  // abort beats a sample on the same edge
  assign last    = (idx == LAST);
  assign idx_inc = idx + N_BITS'(1);

  // Each accepted vector reloads the full settle wait; leaving RUN parks the counter at 0.
  assign cnt_load = accept || sample || kill;
  assign cnt_val  = (accept || (sample && !last)) ? CNT_W'(SETTLE) : '0;

  power1_settle_cnt u_settle_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .en       (state == RUN),
    .load_val (cnt_val),
    .tc       (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start) state_d = RUN;
      RUN: begin
        if (abort)            state_d = IDLE;
        else if (tc && last)  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // NOTE: table_q is a small flop array (TW <= 16), so it takes the async reset like any register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      a         <= '0;
      table_q   <= '0;
      table_vld <= 1'b0;
    end else if (accept) begin
      idx       <= '0;
      a         <= '0;
      table_vld <= 1'b0;
    end else if (kill) begin
      idx <= '0;
      a   <= '0;
    end else if (sample) begin
      table_q[idx] <= y;
      if (last) begin
        idx       <= '0;
        a         <= '0;
        table_vld <= 1'b1;
      end else begin
        idx <= idx_inc;
        a   <= A_W'(idx_inc);
      end
    end
  end

`ifdef POWER1_SWEEP_CHECK_EN
  function automatic logic [N_BITS-1:0] first_diff(input logic [TW-1:0] d);
    first_diff = '0;
    for (int i = TW - 1; i >= 0; i--) begin
      if (d[i]) first_diff = N_BITS'(i);
    end
  endfunction

  // table_q already holds the final sample while in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match        <= 1'b0;
      mismatch_idx <= '0;
    end else if (accept) begin
      match        <= 1'b0;
      mismatch_idx <= '0;
    end else if (state == DONE) begin
      match        <= (table_q == exp_table);
      mismatch_idx <= first_diff(table_q ^ exp_table);
    end
  end
`endif

endmodule

// File: tb/tb_power1_sweep_ctrl.sv
// Randomized bench for power1_sweep_ctrl: two instances (SETTLE=1 and SETTLE=0) against a timing/table model.
module tb_power1_sweep_ctrl;

  localparam int TW = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       abort;
  logic       start_i [2];
  logic [3:0] a_o     [2];
  logic       y_i     [2];
  logic       busy_o  [2];
  logic       done_o  [2];
  logic [7:0] tbl_o   [2];
  logic       vld_o   [2];
  logic [7:0] tt      [2];
`ifdef POWER1_SWEEP_CHECK_EN
  logic [7:0] exp_tbl [2];
  logic       match_o [2];
  logic [2:0] mis_o   [2];
  int         cmp_sel = 0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Behavioural power1: the bench's truth table indexed by the swept vector.
  assign y_i[0] = tt[0][a_o[0][2:0]];
  assign y_i[1] = tt[1][a_o[1][2:0]];

  power1_sweep_ctrl #(.N_BITS(3), .SETTLE(1)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_i[0]), .abort(abort),
    .a(a_o[0]), .y(y_i[0]),
`ifdef POWER1_SWEEP_CHECK_EN
    .exp_table(exp_tbl[0]), .match(match_o[0]), .mismatch_idx(mis_o[0]),
`endif
    .busy(busy_o[0]), .done(done_o[0]), .table_q(tbl_o[0]), .table_vld(vld_o[0])
  );

  power1_sweep_ctrl #(.N_BITS(3), .SETTLE(0)) u_dut_s0 (
    .clk(clk), .rst_n(rst_n), .start(start_i[1]), .abort(abort),
    .a(a_o[1]), .y(y_i[1]),
`ifdef POWER1_SWEEP_CHECK_EN
    .exp_table(exp_tbl[1]), .match(match_o[1]), .mismatch_idx(mis_o[1]),
`endif
    .busy(busy_o[1]), .done(done_o[1]), .table_q(tbl_o[1]), .table_vld(vld_o[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int settle_of(input int u);
    return (u == 0) ? 1 : 0;
  endfunction

  task automatic check_zero(input int u, input string tag);
    check({tag, "_a"},    32'(a_o[u]),    32'd0);
    check({tag, "_busy"}, 32'(busy_o[u]), 32'd0);
    check({tag, "_done"}, 32'(done_o[u]), 32'd0);
    check({tag, "_tbl"},  32'(tbl_o[u]),  32'd0);
    check({tag, "_vld"},  32'(vld_o[u]),  32'd0);
  endtask

  // One sweep on unit u with truth table tv. abort_k>0 asserts abort for edge E0+abort_k;
  // hold keeps start high through DONE to show that exactly one new sweep follows IDLE.
  task automatic sweep(input int u, input logic [7:0] tv, input int abort_k, input bit hold);
    int s, len, last_k, exp_a;
    bit aborted, seen;
    logic exp_busy, exp_done, exp_vld;
`ifdef POWER1_SWEEP_CHECK_EN
    logic [7:0] ex;
    int         exp_mis;
    if (cmp_sel == 0)      ex = tv;
    else if (cmp_sel == 1) ex = tv ^ 8'h01;
    else if ($urandom_range(1, 0) == 1) ex = tv;
    else                   ex = tv ^ (8'h01 << $urandom_range(7, 0));
    cmp_sel++;
    exp_tbl[u] = ex;
    exp_mis = 0;
    for (int i = TW - 1; i >= 0; i--) if (tv[i] != ex[i]) exp_mis = i;
`endif
    s      = settle_of(u);
    len    = TW * (s + 1);
    last_k = hold ? len + 2 : len + 1;
    tt[u]  = tv;
    @(negedge clk);
    start_i[u] = 1'b1;
    for (int k = 0; k <= last_k; k++) begin
      @(negedge clk);  // outputs after edge E0+k
      aborted  = (abort_k > 0) && (k >= abort_k);
      exp_busy = (!aborted && k < len) || (hold && k == len + 2);
      exp_done = !aborted && k == len;
      exp_vld  = !aborted && (k == len || k == len + 1);
      exp_a    = (!aborted && k < len) ? k / (s + 1) : 0;
      check("a",    32'(a_o[u]),    32'(exp_a));
      check("busy", 32'(busy_o[u]), 32'(exp_busy));
      check("done", 32'(done_o[u]), 32'(exp_done));
      check("vld",  32'(vld_o[u]),  32'(exp_vld));
      if (!aborted && k == len) check("table", 32'(tbl_o[u]), 32'(tv));
`ifdef POWER1_SWEEP_CHECK_EN
      if (k == len + 1) begin
        check("match",    32'(match_o[u]), aborted ? 32'd0 : 32'(tv == ex));
        check("mism_idx", 32'(mis_o[u]),   aborted ? 32'd0 : 32'(exp_mis));
      end
`endif
      if (k == 0 && !hold)   start_i[u] = 1'b0;
      if (k == abort_k - 1)  abort = 1'b1;
      if (k == abort_k)      abort = 1'b0;
    end
    if (hold) begin
      start_i[u] = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 4 * len && !seen; c++) begin
        @(negedge clk);
        seen = done_o[u];
      end
      check("hold_second_done", 32'(seen), 32'd1);
      check("hold_second_tbl",  32'(tbl_o[u]), 32'(tv));
      @(negedge clk);
      check("hold_idle_busy", 32'(busy_o[u]), 32'd0);
    end
  endtask

  task automatic reset_mid(input int u);
    tt[u] = 8'h96;
    @(negedge clk);
    start_i[u] = 1'b1;
    @(negedge clk);
    start_i[u] = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    check("mid_busy", 32'(busy_o[u]), 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero(u, "rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int u, ab, len;
    logic [7:0] tv;
    rst_n      = 1'b0;
    abort      = 1'b0;
    start_i[0] = 1'b0;
    start_i[1] = 1'b0;
    tt[0]      = 8'h00;
    tt[1]      = 8'h00;
`ifdef POWER1_SWEEP_CHECK_EN
    exp_tbl[0] = 8'h00;
    exp_tbl[1] = 8'h00;
`endif
    #12;
    check_zero(0, "rst0");
    check_zero(1, "rst1");
    @(negedge clk);
    rst_n = 1'b1;

    sweep(0, 8'h96, -1, 1'b0);  // y = ^a[2:0], SETTLE=1
    sweep(1, 8'h80, -1, 1'b0);  // y = &a[2:0], SETTLE=0
    sweep(0, 8'h96,  5, 1'b0);  // abort at E0+5
    sweep(0, 8'h96, -1, 1'b0);  // clean sweep after abort
    sweep(0, 8'h96, -1, 1'b1);  // start held through DONE
    reset_mid(0);

    for (int i = 0; i < 8; i++) begin
      u   = int'($urandom_range(1, 0));
      tv  = 8'($urandom);
      len = TW * (settle_of(u) + 1);
      ab  = ($urandom_range(3, 0) == 0) ? int'($urandom_range(len, 1)) : -1;
      sweep(u, tv, ab, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
